// File: rtl/mem_dump_reader.sv
// ---------------------------------------------------------------------------
// mem_dump_reader
//
// Walks data-memory words 0..NUM_WORDS-1 through the memory's asynchronous
// read port and streams each 32-bit word as four bytes, MSB first, on a
// valid/ready byte interface toward the debug UART transmitter.
//
// Ports:
//   clka      in   sole clock, rising edge
//   reset     in   asynchronous active-low reset
//   start     in   dump request, honoured only while idle
//   mem_addr  out  word address to the memory read port
//   mem_dout  in   memory read data, combinational from mem_addr
//   tx_data   out  byte to the transmitter
//   tx_valid  out  tx_data is valid
//   tx_ready  in   transmitter accepts the byte this cycle
//   busy      out  high whenever a dump is in progress (not IDLE)
//   done      out  one-cycle pulse after the last byte is accepted
// ---------------------------------------------------------------------------
module mem_dump_reader #(
  parameter int DATA_WIDTH = 32,
  parameter int MEM_WIDTH  = 4,
  parameter int NUM_WORDS  = 10
) (
  input  logic                  clka,
  input  logic                  reset,
  input  logic                  start,
  output logic [MEM_WIDTH-1:0]  mem_addr,
  input  logic [DATA_WIDTH-1:0] mem_dout,
  output logic [7:0]            tx_data,
  output logic                  tx_valid,
  input  logic                  tx_ready,
  output logic                  busy,
  output logic                  done
);

  // Elaboration-time guards on the parameter ranges.
  if (DATA_WIDTH != 32) begin : g_bad_data_width
    $error("mem_dump_reader: DATA_WIDTH must be 32");
  end
  if (NUM_WORDS < 1 || NUM_WORDS > (2 ** MEM_WIDTH)) begin : g_bad_num_words
    $error("mem_dump_reader: NUM_WORDS out of range");
  end

  localparam logic [MEM_WIDTH-1:0] LAST_ADDR = MEM_WIDTH'(NUM_WORDS - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    SEND = 2'd2,
    DONE = 2'd3
  } state_t;

  state_t                  state_reg;
  logic [DATA_WIDTH-1:0]   shreg_reg;
  logic [1:0]              byte_cnt_reg;
  logic [MEM_WIDTH-1:0]    addr_reg;
  logic                    tx_valid_reg;
  logic                    busy_reg;
  logic                    done_reg;

  // Single FSM process; every output is a flop or a direct slice of one,
  // so neither start nor tx_ready reaches an output combinationally.
  always_ff @(posedge clka or negedge reset) begin
    if (!reset) begin
      state_reg    <= IDLE;
      shreg_reg    <= '0;
      byte_cnt_reg <= '0;
      addr_reg     <= '0;
      tx_valid_reg <= 1'b0;
      busy_reg     <= 1'b0;
      done_reg     <= 1'b0;
    end else begin
      case (state_reg)
        IDLE: begin
          if (start) begin
            addr_reg  <= '0;
            busy_reg  <= 1'b1;
            state_reg <= LOAD;
          end
        end

        LOAD: begin
          // The word is captured here only; later memory writes cannot
          // disturb the bytes already queued in shreg.
          shreg_reg    <= mem_dout;
          byte_cnt_reg <= '0;
          tx_valid_reg <= 1'b1;
          state_reg    <= SEND;
        end

        SEND: begin
          if (tx_valid_reg && tx_ready) begin
            // After four shifts shreg is all zero, which keeps tx_data at
            // 0x00 outside SEND without any extra gating.
            shreg_reg    <= shreg_reg << 8;
            byte_cnt_reg <= byte_cnt_reg + 2'd1;
            if (byte_cnt_reg == 2'd3) begin
              tx_valid_reg <= 1'b0;
              if (addr_reg == LAST_ADDR) begin
                done_reg  <= 1'b1;
                state_reg <= DONE;
              end else begin
                addr_reg  <= addr_reg + MEM_WIDTH'(1);
                state_reg <= LOAD;
              end
            end
          end
        end

        DONE: begin
          // start is deliberately not looked at here: the earliest new
          // dump begins from the first IDLE cycle.
          done_reg  <= 1'b0;
          busy_reg  <= 1'b0;
          addr_reg  <= '0;
          state_reg <= IDLE;
        end

        default: begin
          state_reg <= IDLE;
        end
      endcase
    end
  end

  assign mem_addr = addr_reg;
  assign tx_data  = shreg_reg[DATA_WIDTH-1 -: 8];
  assign tx_valid = tx_valid_reg;
  assign busy     = busy_reg;
  assign done     = done_reg;

endmodule

// File: tb/tb_mem_dump_reader.sv
// ---------------------------------------------------------------------------
// tb_mem_dump_reader
//
// Directed bench for mem_dump_reader. A behavioural memory feeds mem_dout;
// expected bytes are queued when each dump is started and popped as the
// DUT hands bytes over. A second instance with NUM_WORDS = 1 covers the
// single-word byte-order case.
// ---------------------------------------------------------------------------
module tb_mem_dump_reader;

  logic        clka = 1'b0;
  logic        reset;
  always #5 clka = ~clka;

  // Main instance (defaults, NUM_WORDS = 10)
  logic        start;
  logic        tx_ready;
  logic [3:0]  mem_addr;
  logic [31:0] mem_dout;
  logic [7:0]  tx_data;
  logic        tx_valid;
  logic        busy;
  logic        done;
  logic [31:0] mem [0:15];

  assign mem_dout = mem[mem_addr];

  mem_dump_reader dut (
    .clka     (clka),
    .reset    (reset),
    .start    (start),
    .mem_addr (mem_addr),
    .mem_dout (mem_dout),
    .tx_data  (tx_data),
    .tx_valid (tx_valid),
    .tx_ready (tx_ready),
    .busy     (busy),
    .done     (done)
  );

  // Single-word instance
  logic        start1;
  logic        tx_ready1;
  logic [3:0]  mem_addr1;
  logic [31:0] mem_dout1;
  logic [7:0]  tx_data1;
  logic        tx_valid1;
  logic        busy1;
  logic        done1;
  logic [31:0] mem1 [0:15];

  assign mem_dout1 = mem1[mem_addr1];

  mem_dump_reader #(.NUM_WORDS(1)) dut1 (
    .clka     (clka),
    .reset    (reset),
    .start    (start1),
    .mem_addr (mem_addr1),
    .mem_dout (mem_dout1),
    .tx_data  (tx_data1),
    .tx_valid (tx_valid1),
    .tx_ready (tx_ready1),
    .busy     (busy1),
    .done     (done1)
  );

  int         n_vec = 0;
  int         n_err = 0;
  logic [7:0] sb_q [$];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Queue the bytes the current memory image should produce, word 0 first,
  // MSB first.
  task automatic push_expected();
    for (int w = 0; w < 10; w++) begin
      for (int b = 3; b >= 0; b--) begin
        sb_q.push_back(mem[w][8*b +: 8]);
      end
    end
  endtask

  // One full dump on the main instance. bp randomises tx_ready; re_a/re_b
  // are byte counts at which a stray start is raised (-1 = never);
  // wr rewrites word 4 while its bytes are in flight.
  task automatic run_dump(input string name, input bit bp, input int re_a,
                          input int re_b, input bit wr);
    int         e;
    int         stalls;
    int         nbytes;
    int         ndone;
    int         done_e;
    bit         prev_stall;
    bit         wrote;
    logic [7:0] prev_data;
    logic [3:0] prev_addr;
    logic [7:0] exp_b;

    push_expected();
    @(negedge clka);
    start    = 1'b1;
    tx_ready = 1'b1;
    @(negedge clka);
    start  = 1'b0;
    e      = 0;
    stalls = 0;
    nbytes = 0;
    ndone  = 0;
    done_e = -1;
    prev_stall = 1'b0;
    wrote  = 1'b0;
    prev_data = '0;
    prev_addr = '0;

    while (e < 400) begin
      start = 1'b0;
      if (!busy) break;

      if (prev_stall) begin
        chk({name, "_stall_valid"}, 32'(tx_valid), 32'd1);
        chk({name, "_stall_data"},  32'(tx_data),  32'(prev_data));
        chk({name, "_stall_addr"},  32'(mem_addr), 32'(prev_addr));
      end

      tx_ready = bp ? 1'($urandom_range(0, 1)) : 1'b1;
      if (nbytes == re_a || nbytes == re_b) start = 1'b1;

      if (wr && !wrote && tx_valid && nbytes == 17) begin
        mem[4] = 32'h5AC3_0F96;
        wrote  = 1'b1;
      end

      if (tx_valid && tx_ready) begin
        if (sb_q.size() == 0) begin
          chk({name, "_extra_byte"}, 32'(tx_data), 32'hFFFF_FFFF);
        end else begin
          exp_b = sb_q.pop_front();
          chk({name, "_byte"}, 32'(tx_data), 32'(exp_b));
          $display("[%s] byte %0d addr=%0d data=%02h", name, nbytes, mem_addr, tx_data);
        end
        nbytes++;
      end

      prev_stall = tx_valid && !tx_ready;
      if (prev_stall) stalls++;
      prev_data = tx_data;
      prev_addr = mem_addr;

      if (done) begin
        ndone++;
        done_e = e;
        start  = 1'b1;   // falls in the DONE cycle: must be ignored
      end

      @(negedge clka);
      e++;
    end
    start = 1'b0;

    chk({name, "_bytes"},      32'(nbytes), 32'd40);
    chk({name, "_done_count"}, 32'(ndone),  32'd1);
    chk({name, "_done_cycle"}, 32'(done_e), 32'(50 + stalls));
    chk({name, "_total"},      32'(e),      32'(51 + stalls));
    chk({name, "_q_empty"},    32'(sb_q.size()), 32'd0);
    sb_q.delete();

    @(negedge clka);
    chk({name, "_idle_after"}, 32'(busy), 32'd0);
    $display("[%s] dump complete: %0d bytes, %0d stalls, %0d cycles", name, nbytes, stalls, e);
  endtask

  initial begin
    logic [7:0] bo_data  [0:6] = '{8'h00, 8'hDE, 8'hAD, 8'hBE, 8'hEF, 8'h00, 8'h00};
    logic       bo_valid [0:6] = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0};
    logic       bo_done  [0:6] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
    logic       bo_busy  [0:6] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0};

    reset     = 1'b0;
    start     = 1'b0;
    tx_ready  = 1'b0;
    start1    = 1'b0;
    tx_ready1 = 1'b1;
    for (int i = 0; i < 16; i++) begin
      mem[i]  = 32'h1111_1111 * (i + 1);
      mem1[i] = 32'h0;
    end
    mem1[0] = 32'hDEAD_BEEF;

    // Reset state
    repeat (3) @(negedge clka);
    chk("rst_valid", 32'(tx_valid), 32'd0);
    chk("rst_busy",  32'(busy),     32'd0);
    chk("rst_done",  32'(done),     32'd0);
    chk("rst_addr",  32'(mem_addr), 32'd0);
    chk("rst_data",  32'(tx_data),  32'd0);
    chk("rst_busy1", 32'(busy1),    32'd0);
    reset = 1'b1;
    @(negedge clka);
    chk("post_rst_busy", 32'(busy), 32'd0);

    // Byte order on the single-word instance
    start1 = 1'b1;
    @(negedge clka);
    start1 = 1'b0;
    for (int e = 0; e < 7; e++) begin
      chk($sformatf("bo_valid_%0d", e), 32'(tx_valid1), 32'(bo_valid[e]));
      chk($sformatf("bo_data_%0d", e),  32'(tx_data1),  32'(bo_data[e]));
      chk($sformatf("bo_done_%0d", e),  32'(done1),     32'(bo_done[e]));
      chk($sformatf("bo_busy_%0d", e),  32'(busy1),     32'(bo_busy[e]));
      chk($sformatf("bo_addr_%0d", e),  32'(mem_addr1), 32'd0);
      $display("[byte_order] cycle %0d valid=%0b data=%02h done=%0b", e, tx_valid1, tx_data1, done1);
      @(negedge clka);
    end

    run_dump("basic", 1'b0, -1, -1, 1'b0);
    run_dump("backpressure", 1'b1, -1, -1, 1'b0);
    run_dump("start_busy", 1'b0, 5, 20, 1'b0);

    // Reset mid-operation: word 3, byte 2 is on the bus 18 cycles after start
    @(negedge clka);
    start    = 1'b1;
    tx_ready = 1'b1;
    @(negedge clka);
    start = 1'b0;
    repeat (18) @(negedge clka);
    chk("mid_pre_data", 32'(tx_data),  32'h44);
    chk("mid_pre_addr", 32'(mem_addr), 32'd3);
    #2 reset = 1'b0;
    #1;
    chk("mid_rst_valid", 32'(tx_valid), 32'd0);
    chk("mid_rst_busy",  32'(busy),     32'd0);
    chk("mid_rst_done",  32'(done),     32'd0);
    chk("mid_rst_addr",  32'(mem_addr), 32'd0);
    chk("mid_rst_data",  32'(tx_data),  32'd0);
    $display("[reset_mid] async reset applied: valid=%0b busy=%0b addr=%0d", tx_valid, busy, mem_addr);
    @(negedge clka);
    reset = 1'b1;
    @(negedge clka);
    chk("mid_release_busy", 32'(busy), 32'd0);
    run_dump("after_reset", 1'b0, -1, -1, 1'b0);

    // Write during SEND: old word 4 now, new word 4 on the following dump
    run_dump("write_send", 1'b0, -1, -1, 1'b1);
    run_dump("after_write", 1'b0, -1, -1, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  // Hard stop in case something wedges outside the bounded loops.
  initial begin
    #200000;
    $display("FAIL timeout simulation did not finish");
    $fatal(1, "timeout");
  end

endmodule
